// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU:
// command encodings, FSM states and default width.
package alu_pkg;

    localparam int DEF_WIDTH = 32;

    localparam logic [3:0] CMD_ADD  = 4'b0000;
    localparam logic [3:0] CMD_SUB  = 4'b0001;
    localparam logic [3:0] CMD_XOR  = 4'b0010;
    localparam logic [3:0] CMD_SLT  = 4'b0011;
    localparam logic [3:0] CMD_AND  = 4'b0100;
    localparam logic [3:0] CMD_NAND = 4'b0101;
    localparam logic [3:0] CMD_NOR  = 4'b0110;
    localparam logic [3:0] CMD_OR   = 4'b0111;
    localparam logic [3:0] CMD_MUL  = 4'b1000;
    localparam logic [3:0] CMD_SLL  = 4'b1001;
    localparam logic [3:0] CMD_SRL  = 4'b1010;
    localparam logic [3:0] CMD_SRA  = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle ALU ops with flags.
// MUL and reserved codes produce zero result and flags.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [3:0]       cmd,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res,
    output logic             cout,
    output logic             ovf
);

    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    logic             sub_op;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic             ovf_as;
    logic [SHW-1:0]   sh;

    assign sub_op = (cmd == CMD_SUB) || (cmd == CMD_SLT);
    assign b_eff  = sub_op ? ~b : b;
    assign sum    = {1'b0, a} + {1'b0, b_eff} + (WIDTH+1)'(sub_op);
    assign ovf_as = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]);
    assign sh     = b[SHW-1:0];

    // Decode the command into result and flags
    always_comb begin
        res  = '0;
        cout = 1'b0;
        ovf  = 1'b0;
        unique case (1'b1)
            cmd == CMD_ADD,
            cmd == CMD_SUB: begin
                res  = sum[WIDTH-1:0];
                cout = sum[WIDTH];
                ovf  = ovf_as;
            end
            cmd == CMD_SLT:  res = WIDTH'(sum[MSB] ^ ovf_as);
            cmd == CMD_XOR:  res = a ^ b;
            cmd == CMD_AND:  res = a & b;
            cmd == CMD_NAND: res = ~(a & b);
            cmd == CMD_NOR:  res = ~(a | b);
            cmd == CMD_OR:   res = a | b;
            cmd == CMD_SLL:  res = a << sh;
            cmd == CMD_SRL:  res = a >> sh;
            cmd == CMD_SRA:  res = $signed(a) >>> sh;
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU: registered single-cycle ops plus
// an iterative shift-add unsigned multiplier.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       command,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             carryout,
    output logic             zero,
    output logic             overflow
);

    localparam int SHW = $clog2(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] mcand;
    logic [SHW-1:0]   cnt;
    logic             accept;
    logic             is_mul;
    logic [WIDTH-1:0] core_res;
    logic             core_c;
    logic             core_v;
    logic [WIDTH:0]   part;
    logic [WIDTH-1:0] hi_nxt;
    logic [WIDTH-1:0] lo_nxt;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .cmd  (command),
        .a    (operandA),
        .b    (operandB),
        .res  (core_res),
        .cout (core_c),
        .ovf  (core_v)
    );

    assign in_ready = rst_n &&
        (state == ST_IDLE || (state == ST_HOLD && out_ready));
    assign accept = in_valid && in_ready;
    assign is_mul = (command == CMD_MUL);

    // During MUL, {result_hi, result} is the product/multiplier
    // register: add multiplicand on low bit, then shift right.
    assign part   = {1'b0, result_hi}
                  + (result[0] ? {1'b0, mcand} : '0);
    assign hi_nxt = part[WIDTH:1];
    assign lo_nxt = {part[0], result[WIDTH-1:1]};

    // Control FSM, operand latch, multiplier and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            mcand     <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            result_hi <= '0;
            carryout  <= 1'b0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE, ST_HOLD: begin
                    if (accept && is_mul) begin
                        state     <= ST_MUL;
                        mcand     <= operandA;
                        cnt       <= SHW'(WIDTH - 1);
                        out_valid <= 1'b0;
                        result    <= operandB;
                        result_hi <= '0;
                        carryout  <= 1'b0;
                        zero      <= 1'b0;
                        overflow  <= 1'b0;
                    end else if (accept) begin
                        state     <= ST_HOLD;
                        out_valid <= 1'b1;
                        result    <= core_res;
                        result_hi <= '0;
                        carryout  <= core_c;
                        zero      <= (core_res == '0);
                        overflow  <= core_v;
                    end else if (state == ST_HOLD && out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                ST_MUL: begin
                    result_hi <= hi_nxt;
                    result    <= lo_nxt;
                    if (cnt == '0) begin
                        state     <= ST_HOLD;
                        out_valid <= 1'b1;
                        carryout  <= (hi_nxt != '0);
                        zero      <= (lo_nxt == '0);
                    end else begin
                        cnt <= cnt - SHW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: directed plan cases,
// then randomized ops with random output backpressure.
module tb_alu_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  command = 4'd0;
    logic [31:0] operandA = '0;
    logic [31:0] operandB = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic [31:0] result_hi;
    logic        carryout;
    logic        zero;
    logic        overflow;

    typedef struct {
        logic [31:0] r;
        logic [31:0] hi;
        logic        c;
        logic        z;
        logic        v;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    bit   rand_bp = 1'b0;

    alu_pipe #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .command   (command),
        .operandA  (operandA),
        .operandB  (operandB),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .carryout  (carryout),
        .zero      (zero),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model from the arithmetic definitions
    function automatic exp_t model(input logic [3:0] c,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        exp_t   e;
        longint sa, sb, t;
        logic [63:0] ua, ub, p;
        int sh;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        sh = int'(b[4:0]);
        e = '{r: 32'd0, hi: 32'd0, c: 1'b0, z: 1'b0, v: 1'b0};
        case (c)
            4'd0: begin
                p = ua + ub;
                e.r = p[31:0];
                e.c = p[32];
                t = sa + sb;
                e.v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            end
            4'd1: begin
                e.r = a - b;
                e.c = (a >= b);
                t = sa - sb;
                e.v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            end
            4'd2: e.r = a ^ b;
            4'd3: e.r = (sa < sb) ? 32'd1 : 32'd0;
            4'd4: e.r = a & b;
            4'd5: e.r = ~(a & b);
            4'd6: e.r = ~(a | b);
            4'd7: e.r = a | b;
            4'd8: begin
                p = ua * ub;
                e.r = p[31:0];
                e.hi = p[63:32];
                e.c = (e.hi != 0);
            end
            4'd9: begin
                p = ua << sh;
                e.r = p[31:0];
            end
            4'd10: begin
                p = ua >> sh;
                e.r = p[31:0];
            end
            4'd11: begin
                t = sa >>> sh;
                e.r = t[31:0];
            end
            default: e.r = 32'd0;
        endcase
        e.z = (e.r == 0);
        return e;
    endfunction

    // Monitor: pop and compare on every output handshake
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", {32'd0, result}, 64'hDEAD);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("result", {32'd0, result}, {32'd0, e.r});
                chk("result_hi", {32'd0, result_hi}, {32'd0, e.hi});
                chk("flags", {61'd0, carryout, zero, overflow},
                    {61'd0, e.c, e.z, e.v});
            end
        end
    end

    // Offer one op, wait (bounded) for acceptance, record expectation
    task automatic send(input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b);
        bit done;
        done = 1'b0;
        command  = c;
        operandA = a;
        operandB = b;
        in_valid = 1'b1;
        if (rand_bp) out_ready = ($urandom_range(0, 2) != 0);
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(model(c, a, b));
                @(posedge clk);
                #1;
                acc_cyc = cyc;
                done = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                if (rand_bp) out_ready = $urandom_range(0, 1);
            end
        end
        if (!done) chk("accept_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
        command  = 4'($urandom);
        operandA = $urandom;
        operandB = $urandom;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++)
            @(posedge clk);
        chk("drain", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] sp [4];
        sp[0] = 32'h0;
        sp[1] = 32'hFFFF_FFFF;
        sp[2] = 32'h8000_0000;
        sp[3] = 32'h7FFF_FFFF;
        if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 3)];
        return $urandom;
    endfunction

    initial begin
        int bad;
        #2;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_zero", {63'd0, zero}, 64'd0);
        chk("rst_result", {32'd0, result}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;

        send(4'd7, 32'hC, 32'hA);
        @(negedge clk);
        chk("or_latency", {63'd0, out_valid}, 64'd1);
        @(posedge clk);
        #1;
        send(4'd6, 32'hC, 32'hA);
        send(4'd0, 32'h7FFF_FFFF, 32'd14000);
        send(4'd1, 32'h2A0, 32'h2A0);
        send(4'd3, 32'hDA00_0004, 32'h3E8);
        send(4'd11, 32'h8000_0000, 32'd4);
        send(4'd10, 32'h8000_0000, 32'd4);
        send(4'd14, 32'h1234, 32'h5678);

        send(4'd8, 32'h0001_0000, 32'h0001_0000);
        bad = 0;
        for (int i = 0; i < 40 && !out_valid; i++) begin
            @(negedge clk);
            if (!out_valid && in_ready !== 1'b0) bad = 1;
        end
        chk("mul_in_ready_low", 64'(bad), 64'd0);
        chk("mul_latency", 64'(cyc - acc_cyc), 64'd32);
        @(posedge clk);
        #1;
        send(4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        drain();

        out_ready = 1'b0;
        send(4'd0, 32'd3, 32'd4);
        command  = 4'd1;
        operandA = 32'd10;
        operandB = 32'd2;
        in_valid = 1'b1;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (result !== 32'd7 || out_valid !== 1'b1 ||
                in_ready !== 1'b0) bad = 1;
        end
        chk("backpressure_hold", 64'(bad), 64'd0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(4'd1, 32'd10, 32'd2);
        @(negedge clk);
        chk("bp_next_valid", {63'd0, out_valid}, 64'd1);
        chk("bp_next_result", {32'd0, result}, 64'd8);
        drain();

        send(4'd8, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_outputs", {result_hi, result}, 64'd0);
        chk("arst_flags", {61'd0, carryout, zero, overflow}, 64'd0);
        chk("arst_in_ready", {63'd0, in_ready}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        send(4'd0, 32'd1, 32'd1);
        drain();

        rand_bp = 1'b1;
        for (int n = 0; n < 250; n++) begin
            logic [3:0] c;
            c = 4'($urandom_range(0, 15));
            if (c == 4'd8 && $urandom_range(0, 1) == 0) c = 4'd0;
            send(c, pick(), pick());
        end
        rand_bp = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
